// File: rtl/run_monitor_if.sv
// Commit bus from the CPU writeback stage into the run monitor.
// One committed pc/instr pair per cycle when pc_valid is high.
interface run_monitor_if #(
    parameter int XLEN = 32
);
    logic            pc_valid;
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;

    modport master (output pc_valid, pc, instr);
    modport slave  (input  pc_valid, pc, instr);
endinterface

// File: rtl/run_monitor.sv
// Run monitor: watches the commit stream and halts on breakpoint,
// ebreak, a stuck PC or a run timeout; keeps cycle/retire counters.
module run_monitor #(
    parameter int XLEN        = 32,
    parameter int NBP         = 4,
    parameter int STALL_LIMIT = 16,
    parameter int TIMEOUT     = 100000,
    parameter int CYC_W       = 32
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                en,
    run_monitor_if.slave        cm,
    input  logic [NBP*XLEN-1:0] bp_addr,
    input  logic [NBP-1:0]      bp_en,
    input  logic                clear,
    output logic                halted,
    output logic [2:0]          halt_cause,
    output logic [XLEN-1:0]     halt_pc,
    output logic [2:0]          halt_bp_idx,
    output logic [CYC_W-1:0]    cycle_cnt,
    output logic [CYC_W-1:0]    retire_cnt,
    output logic                trace_valid,
    output logic [XLEN-1:0]     trace_pc,
    output logic [31:0]         trace_instr
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALT
    } state_t;

    localparam logic [2:0]  C_NONE = 3'd0;
    localparam logic [2:0]  C_BP   = 3'd1;
    localparam logic [2:0]  C_EBRK = 3'd2;
    localparam logic [2:0]  C_STCK = 3'd3;
    localparam logic [2:0]  C_TOUT = 3'd4;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    localparam int SW = $clog2(STALL_LIMIT + 1);
    localparam logic [SW-1:0]    STUCK_LAST = SW'(STALL_LIMIT - 1);
    localparam logic [CYC_W-1:0] TO_LAST    = CYC_W'(TIMEOUT - 1);

    state_t state, state_nx;

    logic [XLEN-1:0] last_pc;
    logic            have_last;
    logic [SW-1:0]   stuck_cnt;

    logic            bp_hit;
    logic [2:0]      bp_idx;
    logic            ebrk_hit;
    logic            same_pc;
    logic            stuck_hit;
    logic            to_hit;
    logic            trig;
    logic            run_commit;
    logic [2:0]      cause_nx;
    logic [XLEN-1:0] pc_nx;
    logic [2:0]      idx_nx;

    // Descending scan so the lowest matching channel is the one kept.
    always_comb begin
        bp_hit = 1'b0;
        bp_idx = 3'd0;
        for (int i = NBP - 1; i >= 0; i--) begin
            if (cm.pc_valid && bp_en[i] &&
                cm.pc == bp_addr[i*XLEN +: XLEN]) begin
                bp_hit = 1'b1;
                bp_idx = 3'(i);
            end
        end
    end

    assign ebrk_hit  = cm.pc_valid && (cm.instr == EBREAK);
    assign same_pc   = cm.pc_valid && have_last && (cm.pc == last_pc);
    assign stuck_hit = same_pc && (stuck_cnt == STUCK_LAST);
    assign to_hit    = (TIMEOUT != 0) && (cycle_cnt == TO_LAST);

    always_comb begin
        cause_nx = C_NONE;
        pc_nx    = '0;
        idx_nx   = 3'd0;
        if (bp_hit) begin
            cause_nx = C_BP;
            pc_nx    = cm.pc;
            idx_nx   = bp_idx;
        end else if (ebrk_hit) begin
            cause_nx = C_EBRK;
            pc_nx    = cm.pc;
        end else if (stuck_hit) begin
            cause_nx = C_STCK;
            pc_nx    = cm.pc;
        end else if (to_hit) begin
            cause_nx = C_TOUT;
            pc_nx    = cm.pc_valid ? cm.pc : last_pc;
        end
    end

    assign trig       = (state == S_RUN) && (cause_nx != C_NONE);
    assign run_commit = (state == S_RUN) && cm.pc_valid;

    always_ff @(posedge clk) begin
        if (rstn) state <= S_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: if (en) state_nx = S_RUN;
            S_RUN: begin
                if (trig)     state_nx = S_HALT;
                else if (!en) state_nx = S_IDLE;
            end
            S_HALT: if (clear) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        halted = (state == S_HALT);
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            cycle_cnt   <= '0;
            retire_cnt  <= '0;
            last_pc     <= '0;
            have_last   <= 1'b0;
            stuck_cnt   <= '0;
            halt_cause  <= C_NONE;
            halt_pc     <= '0;
            halt_bp_idx <= 3'd0;
            trace_valid <= 1'b0;
            trace_pc    <= '0;
            trace_instr <= '0;
        end else begin
            trace_valid <= run_commit;
            if (run_commit) begin
                trace_pc    <= cm.pc;
                trace_instr <= cm.instr;
            end
            unique case (state)
                S_RUN: begin
                    if (cycle_cnt != '1)
                        cycle_cnt <= cycle_cnt + 1'b1;
                    if (cm.pc_valid) begin
                        if (retire_cnt != '1)
                            retire_cnt <= retire_cnt + 1'b1;
                        last_pc   <= cm.pc;
                        have_last <= 1'b1;
                        stuck_cnt <= same_pc ? stuck_cnt + 1'b1
                                             : SW'(1);
                    end
                    if (trig) begin
                        halt_cause  <= cause_nx;
                        halt_pc     <= pc_nx;
                        halt_bp_idx <= idx_nx;
                    end
                end
                S_HALT: begin
                    if (clear) begin
                        cycle_cnt   <= '0;
                        retire_cnt  <= '0;
                        last_pc     <= '0;
                        have_last   <= 1'b0;
                        stuck_cnt   <= '0;
                        halt_cause  <= C_NONE;
                        halt_pc     <= '0;
                        halt_bp_idx <= 3'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_run_monitor.sv
// Directed bench for run_monitor: one instance for breakpoint/stuck/
// pause/reset scenarios, a second with a short timeout.
module tb_run_monitor;

    localparam int XLEN = 32;
    localparam int NBP  = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] EBK = 32'h0010_0073;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic                rstn, en, clear;
    logic [NBP*XLEN-1:0] bp_addr;
    logic [NBP-1:0]      bp_en;
    logic                halted;
    logic [2:0]          halt_cause, halt_bp_idx;
    logic [XLEN-1:0]     halt_pc, trace_pc;
    logic [31:0]         cycle_cnt, retire_cnt, trace_instr;
    logic                trace_valid;

    run_monitor_if #(.XLEN(XLEN)) ifa ();

    run_monitor #(
        .XLEN(XLEN), .NBP(NBP), .STALL_LIMIT(4),
        .TIMEOUT(1000), .CYC_W(32)
    ) dut (
        .clk(clk), .rstn(rstn), .en(en), .cm(ifa.slave),
        .bp_addr(bp_addr), .bp_en(bp_en), .clear(clear),
        .halted(halted), .halt_cause(halt_cause),
        .halt_pc(halt_pc), .halt_bp_idx(halt_bp_idx),
        .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt),
        .trace_valid(trace_valid), .trace_pc(trace_pc),
        .trace_instr(trace_instr)
    );

    logic                rstn_t, en_t, clear_t;
    logic [NBP*XLEN-1:0] bp_addr_t;
    logic [NBP-1:0]      bp_en_t;
    logic                halted_t;
    logic [2:0]          cause_t, idx_t;
    logic [XLEN-1:0]     hpc_t, tpc_t;
    logic [31:0]         cyc_t, ret_t, tins_t;
    logic                tval_t;

    run_monitor_if #(.XLEN(XLEN)) ift ();

    run_monitor #(
        .XLEN(XLEN), .NBP(NBP), .STALL_LIMIT(4),
        .TIMEOUT(8), .CYC_W(32)
    ) dut_t (
        .clk(clk), .rstn(rstn_t), .en(en_t), .cm(ift.slave),
        .bp_addr(bp_addr_t), .bp_en(bp_en_t), .clear(clear_t),
        .halted(halted_t), .halt_cause(cause_t),
        .halt_pc(hpc_t), .halt_bp_idx(idx_t),
        .cycle_cnt(cyc_t), .retire_cnt(ret_t),
        .trace_valid(tval_t), .trace_pc(tpc_t),
        .trace_instr(tins_t)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        en = 0; clear = 0; bp_en = '0;
        ifa.pc_valid = 0; ifa.pc = '0; ifa.instr = NOP;
    endtask

    task automatic commit(input logic v, input logic [31:0] p,
                          input logic [31:0] ins);
        ifa.pc_valid = v; ifa.pc = p; ifa.instr = ins;
        step();
    endtask

    task automatic do_clear();
        en = 0; clear = 1; ifa.pc_valid = 0;
        step();
        clear = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rstn = 1; rstn_t = 1;
        step(); step();
        rstn = 0; rstn_t = 0;
        n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL rst_halted got %0h want 0", halted); end
        n_cmp++; if (halt_cause !== 3'd0) begin n_err++; $display("FAIL rst_cause got %0h want 0", halt_cause); end
        n_cmp++; if (cycle_cnt !== 32'd0 || retire_cnt !== 32'd0) begin n_err++; $display("FAIL rst_cnt got %0h/%0h want 0/0", cycle_cnt, retire_cnt); end
        n_cmp++; if (trace_valid !== 1'b0 || trace_pc !== 32'd0) begin n_err++; $display("FAIL rst_trace got %0h/%0h want 0/0", trace_valid, trace_pc); end
    endtask

    task automatic test_breakpoint();
        idle_inputs();
        bp_addr = '0;
        bp_addr[0*XLEN +: XLEN] = 32'h20;
        bp_addr[1*XLEN +: XLEN] = 32'h20;
        bp_addr[2*XLEN +: XLEN] = 32'h20;
        bp_addr[3*XLEN +: XLEN] = 32'h20;
        bp_en = 4'b0110;
        en = 1;
        step();
        for (int k = 0; k < 9; k++) begin
            commit(1'b1, 32'(k * 4), NOP);
            if (k < 8) begin
                n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL bp_early k=%0d got %0h want 0", k, halted); end
            end
        end
        n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL bp_halted got %0h want 1", halted); end
        n_cmp++; if (halt_cause !== 3'd1) begin n_err++; $display("FAIL bp_cause got %0h want 1", halt_cause); end
        n_cmp++; if (halt_bp_idx !== 3'd1) begin n_err++; $display("FAIL bp_idx got %0h want 1", halt_bp_idx); end
        n_cmp++; if (halt_pc !== 32'h20) begin n_err++; $display("FAIL bp_pc got %0h want 20", halt_pc); end
        n_cmp++; if (retire_cnt !== 32'd9 || cycle_cnt !== 32'd9) begin n_err++; $display("FAIL bp_cnt got %0d/%0d want 9/9", retire_cnt, cycle_cnt); end
        n_cmp++; if (trace_valid !== 1'b1 || trace_pc !== 32'h20) begin n_err++; $display("FAIL bp_trace got %0h/%0h want 1/20", trace_valid, trace_pc); end
        commit(1'b1, 32'h10, EBK);
        n_cmp++; if (halt_cause !== 3'd1 || halt_pc !== 32'h20) begin n_err++; $display("FAIL halt_hold got %0h/%0h want 1/20", halt_cause, halt_pc); end
        n_cmp++; if (retire_cnt !== 32'd9 || cycle_cnt !== 32'd9) begin n_err++; $display("FAIL halt_cnt got %0d/%0d want 9/9", retire_cnt, cycle_cnt); end
        n_cmp++; if (trace_valid !== 1'b0) begin n_err++; $display("FAIL halt_trace got %0h want 0", trace_valid); end
        do_clear();
        n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL clr_halted got %0h want 0", halted); end
        n_cmp++; if (halt_cause !== 3'd0 || halt_bp_idx !== 3'd0 || halt_pc !== 32'd0) begin n_err++; $display("FAIL clr_cause got %0h/%0h/%0h want 0/0/0", halt_cause, halt_bp_idx, halt_pc); end
        n_cmp++; if (cycle_cnt !== 32'd0 || retire_cnt !== 32'd0) begin n_err++; $display("FAIL clr_cnt got %0d/%0d want 0/0", cycle_cnt, retire_cnt); end
    endtask

    task automatic test_stuck();
        logic       v [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
        logic [31:0] p6 [6] = '{32'h40, 32'h40, 32'h44, 32'h44, 32'h44, 32'h44};
        idle_inputs();
        en = 1;
        step();
        for (int k = 0; k < 4; k++) begin
            commit(1'b1, 32'h40, NOP);
            if (k < 3) begin
                n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL stk_early k=%0d got %0h want 0", k, halted); end
            end
        end
        n_cmp++; if (halted !== 1'b1 || halt_cause !== 3'd3 || halt_pc !== 32'h40) begin n_err++; $display("FAIL stk_halt got %0h/%0h/%0h want 1/3/40", halted, halt_cause, halt_pc); end
        do_clear();
        en = 1;
        step();
        for (int k = 0; k < 8; k++) begin
            commit(v[k], v[k] ? 32'h40 : 32'h99, NOP);
            if (k < 7) begin
                n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL stki_early k=%0d got %0h want 0", k, halted); end
            end
        end
        n_cmp++; if (halted !== 1'b1 || halt_cause !== 3'd3 || halt_pc !== 32'h40) begin n_err++; $display("FAIL stki_halt got %0h/%0h/%0h want 1/3/40", halted, halt_cause, halt_pc); end
        do_clear();
        en = 1;
        step();
        for (int k = 0; k < 6; k++) begin
            commit(1'b1, p6[k], NOP);
            if (k < 5) begin
                n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL stkr_early k=%0d got %0h want 0", k, halted); end
            end
        end
        n_cmp++; if (halted !== 1'b1 || halt_cause !== 3'd3 || halt_pc !== 32'h44) begin n_err++; $display("FAIL stkr_halt got %0h/%0h/%0h want 1/3/44", halted, halt_cause, halt_pc); end
        do_clear();
    endtask

    task automatic test_priority();
        idle_inputs();
        bp_addr = '0;
        bp_addr[0*XLEN +: XLEN] = 32'h10;
        bp_addr[3*XLEN +: XLEN] = 32'h30;
        bp_en = 4'b0001;
        en = 1;
        step();
        commit(1'b1, 32'h10, EBK);
        n_cmp++; if (halt_cause !== 3'd1 || halt_bp_idx !== 3'd0 || halt_pc !== 32'h10) begin n_err++; $display("FAIL prio_bp got %0h/%0h/%0h want 1/0/10", halt_cause, halt_bp_idx, halt_pc); end
        do_clear();
        bp_en = 4'b0000; en = 1;
        step();
        commit(1'b1, 32'h8, EBK);
        n_cmp++; if (halt_cause !== 3'd2 || halt_bp_idx !== 3'd0 || halt_pc !== 32'h8) begin n_err++; $display("FAIL ebreak got %0h/%0h/%0h want 2/0/8", halt_cause, halt_bp_idx, halt_pc); end
        do_clear();
        bp_en = 4'b1000; en = 1;
        step();
        commit(1'b1, 32'h30, NOP);
        n_cmp++; if (halt_cause !== 3'd1 || halt_bp_idx !== 3'd3 || halt_pc !== 32'h30) begin n_err++; $display("FAIL bp_ch3 got %0h/%0h/%0h want 1/3/30", halt_cause, halt_bp_idx, halt_pc); end
        do_clear();
    endtask

    task automatic test_timeout();
        en_t = 1;
        step();
        for (int k = 0; k < 7; k++) step();
        n_cmp++; if (halted_t !== 1'b0 || cyc_t !== 32'd7) begin n_err++; $display("FAIL to_early got %0h/%0d want 0/7", halted_t, cyc_t); end
        step();
        n_cmp++; if (halted_t !== 1'b1 || cyc_t !== 32'd8) begin n_err++; $display("FAIL to_halt got %0h/%0d want 1/8", halted_t, cyc_t); end
        n_cmp++; if (cause_t !== 3'd4 || hpc_t !== 32'd0 || ret_t !== 32'd0) begin n_err++; $display("FAIL to_cause got %0h/%0h/%0d want 4/0/0", cause_t, hpc_t, ret_t); end
        step();
        n_cmp++; if (cyc_t !== 32'd8 || halted_t !== 1'b1) begin n_err++; $display("FAIL to_hold got %0d/%0h want 8/1", cyc_t, halted_t); end
        en_t = 0;
    endtask

    task automatic test_pause_clear();
        idle_inputs();
        en = 1;
        step();
        for (int k = 0; k < 4; k++) step();
        n_cmp++; if (cycle_cnt !== 32'd4) begin n_err++; $display("FAIL pz_run got %0d want 4", cycle_cnt); end
        en = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++; if (cycle_cnt !== 32'd5) begin n_err++; $display("FAIL pz_frozen k=%0d got %0d want 5", k, cycle_cnt); end
        end
        en = 1;
        step();
        step();
        n_cmp++; if (cycle_cnt !== 32'd6) begin n_err++; $display("FAIL pz_resume got %0d want 6", cycle_cnt); end
        clear = 1;
        step();
        clear = 0;
        step();
        n_cmp++; if (cycle_cnt !== 32'd8 || halted !== 1'b0 || halt_cause !== 3'd0) begin n_err++; $display("FAIL clr_run got %0d/%0h/%0h want 8/0/0", cycle_cnt, halted, halt_cause); end
    endtask

    task automatic test_reset_midrun();
        idle_inputs();
        rstn = 1;
        step();
        rstn = 0; en = 1;
        step();
        for (int k = 0; k < 5; k++) commit(1'b1, 32'(32'h100 + 4 * k), NOP);
        n_cmp++; if (cycle_cnt !== 32'd5 || retire_cnt !== 32'd5 || trace_pc !== 32'h110) begin n_err++; $display("FAIL mr_pre got %0d/%0d/%0h want 5/5/110", cycle_cnt, retire_cnt, trace_pc); end
        rstn = 1;
        commit(1'b1, 32'h200, EBK);
        n_cmp++; if (cycle_cnt !== 32'd0 || retire_cnt !== 32'd0 || halted !== 1'b0) begin n_err++; $display("FAIL mr_cnt got %0d/%0d/%0h want 0/0/0", cycle_cnt, retire_cnt, halted); end
        n_cmp++; if (trace_valid !== 1'b0 || trace_pc !== 32'd0 || trace_instr !== 32'd0) begin n_err++; $display("FAIL mr_trace got %0h/%0h/%0h want 0/0/0", trace_valid, trace_pc, trace_instr); end
        n_cmp++; if (halt_cause !== 3'd0 || halt_pc !== 32'd0 || halt_bp_idx !== 3'd0) begin n_err++; $display("FAIL mr_cause got %0h/%0h/%0h want 0/0/0", halt_cause, halt_pc, halt_bp_idx); end
        rstn = 0; en = 0; ifa.pc_valid = 0;
        step();
        n_cmp++; if (cycle_cnt !== 32'd0) begin n_err++; $display("FAIL mr_idle got %0d want 0", cycle_cnt); end
    endtask

    initial begin
        rstn = 1; rstn_t = 1; en_t = 0; clear_t = 0;
        bp_addr = '0; bp_addr_t = '0; bp_en_t = '0;
        ift.pc_valid = 0; ift.pc = '0; ift.instr = '0;
        idle_inputs();
        test_reset();
        test_breakpoint();
        test_stuck();
        test_priority();
        test_timeout();
        test_pause_clear();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/run_monitor.md
RUN_MONITOR -- requirements
Module: run_monitor

Interface
REQ-001 Parameter XLEN, default 32, width of the PC and breakpoint addresses.
REQ-002 Parameter NBP, default 4, number of breakpoint channels (1..8).
REQ-003 Parameter STALL_LIMIT, default 16, count of consecutive identical valid PCs that triggers a stuck halt (>=2).
REQ-004 Parameter TIMEOUT, default 100000, number of RUN cycles before a timeout halt; 0 disables the timeout.
REQ-005 Parameter CYC_W, default 32, width of the cycle and retire counters.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 rstn  input  1  synchronous, active-high reset (asserted = 1), despite the name.
REQ-008 en  input  1  run enable.
REQ-009 pc_valid  input  1  the CPU commits pc/instr this cycle.
REQ-010 pc  input  XLEN  committed PC (pcW).
REQ-011 instr  input  32  committed instruction.
REQ-012 bp_addr  input  NBP*XLEN  breakpoint addresses; channel i occupies bits [i*XLEN +: XLEN].
REQ-013 bp_en  input  NBP  per-channel breakpoint enable.
REQ-014 clear  input  1  acknowledges a halt and rearms the monitor.
REQ-015 halted  output  1  monitor is in HALT.
REQ-016 halt_cause  output  3  0 none, 1 breakpoint, 2 ebreak, 3 stuck, 4 timeout.
REQ-017 halt_pc  output  XLEN  PC that caused the halt (for timeout: last valid PC seen, 0 if none).
REQ-018 halt_bp_idx  output  3  breakpoint channel that hit; 0 unless cause is 1.
REQ-019 cycle_cnt  output  CYC_W  RUN cycles elapsed.
REQ-020 retire_cnt  output  CYC_W  valid commits seen in RUN.
REQ-021 trace_valid, trace_pc, trace_instr  output  1/XLEN/32  registered commit trace.

Function
REQ-022 The FSM SHALL have states IDLE, RUN, HALT; the reset state is IDLE.
REQ-023 IDLE->RUN when en=1; RUN->IDLE when en=0 with no halt trigger that cycle (pause: counters, stuck and last-PC state hold).
REQ-024 In RUN, a halt trigger SHALL move to HALT on the next edge; halted=1 starting the cycle after the triggering commit.
REQ-025 Breakpoint trigger: pc_valid && bp_en[i] && pc==bp_addr[i]; the lowest matching index wins.
REQ-026 Ebreak trigger: pc_valid && instr==32'h00100073.
REQ-027 Stuck trigger: pc_valid with pc equal to the previous valid pc, completing STALL_LIMIT consecutive identical valid PCs (the first occurrence counts as 1); a differing PC restarts the count at 1; non-valid cycles neither count nor break the run.
REQ-028 Timeout trigger: TIMEOUT!=0 and cycle_cnt==TIMEOUT-1 in a RUN cycle.
REQ-029 Simultaneous triggers SHALL resolve with priority breakpoint > ebreak > stuck > timeout; exactly one cause is latched.
REQ-030 halt_cause, halt_pc and halt_bp_idx SHALL be latched on entry to HALT and held until clear or reset.
REQ-031 cycle_cnt SHALL increment on every RUN cycle, including the triggering cycle; retire_cnt SHALL increment on every RUN cycle with pc_valid; both SHALL saturate at all-ones.
REQ-032 Counters SHALL hold in IDLE and HALT.
REQ-033 trace_valid SHALL equal the previous cycle's (pc_valid && state==RUN), with trace_pc/trace_instr carrying that cycle's pc/instr (1-cycle latency); the triggering commit is traced.
REQ-034 In HALT, pc_valid and triggers SHALL be ignored; HALT->IDLE on clear=1.
REQ-035 On HALT->IDLE, all counters, stuck state, last-PC state and latched cause fields SHALL be zeroed.
REQ-036 clear in IDLE or RUN SHALL have no effect.
REQ-037 Breakpoint changes SHALL take effect on the same cycle they are presented (combinational compare).

Reset
REQ-038 With rstn=1 at a rising edge, state=IDLE and every output, counter, stuck state and last-PC state SHALL be 0 on the next cycle, regardless of state (including mid-RUN or HALT); reset has priority over clear and en.

Verification
REQ-039 Breakpoint: bp_en=4'b0110, bp_addr[1]=bp_addr[2]=0x20, en=1, valid PCs 0x0,0x4,...,0x20 -> halted=1 the cycle after pc=0x20, halt_cause=1, halt_bp_idx=1, halt_pc=0x20, retire_cnt=9.
REQ-040 Stuck: STALL_LIMIT=4, valid pc=0x40 repeated for 4 cycles -> halt_cause=3, halt_pc=0x40 after the 4th; with invalid cycles interleaved, it still halts after the 4th valid 0x40.
REQ-041 Priority: pc=0x10 is a breakpoint and instr=0x00100073 on the same commit -> halt_cause=1.
REQ-042 Timeout: TIMEOUT=8, pc_valid=0, en=1 -> halted after 8 RUN cycles, cycle_cnt=8, halt_cause=4, halt_pc=0.
REQ-043 Pause/clear: en dropped for 3 cycles mid-run -> cycle_cnt frozen; after a halt, clear=1 -> next cycle IDLE, counters and cause=0; clear in RUN -> no change.
REQ-044 Reset mid-run: rstn=1 while in RUN with cycle_cnt=5 -> next cycle all outputs 0, state IDLE.
